// File: rtl/motor_control_pkg.sv
// Shared constants and types for the two-channel motor command decoder.
package motor_control_pkg;

  // Default frame header value
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

  // Drive command codes
  localparam logic [7:0] CMD_STOP  = 8'h00;
  localparam logic [7:0] CMD_FWD   = 8'h01;
  localparam logic [7:0] CMD_REV   = 8'h02;
  localparam logic [7:0] CMD_LEFT  = 8'h03;
  localparam logic [7:0] CMD_RIGHT = 8'h04;

  // Motor direction encoding
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Frame parser states
  typedef enum logic {
    WAIT_SYNC = 1'b0,
    WAIT_CMD  = 1'b1
  } state_e;

endpackage

// File: rtl/motor_ramp.sv
// Slew-limited speed/direction stage for one motor. Reversals always pass
// through zero speed; every change happens one step per tick.
module motor_ramp
  import motor_control_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       tick,
  input  logic [7:0] target,
  input  logic       pending_dir,
  output logic       direction_out,
  output logic [7:0] speed_out
);

  logic       dir_q,   dir_d;
  logic [7:0] speed_q, speed_d;

  // Next ramp step: brake before reversing, then approach the target by one.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    dir_d   = dir_q;
    speed_d = speed_q;
    if (tick) begin
      if (dir_q != pending_dir) begin
        if (speed_q != 8'd0) speed_d = speed_q - 8'd1;
        else                 dir_d   = pending_dir;
      end else if (speed_q < target) begin
        speed_d = speed_q + 8'd1;
      end else if (speed_q > target) begin
        speed_d = speed_q - 8'd1;
      end
    end
  end

  // Ramp state registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset_in) begin
      dir_q   <= DIR_FWD;
      speed_q <= 8'd0;
    end else begin
      dir_q   <= dir_d;
      speed_q <= speed_d;
    end
  end

  assign direction_out = dir_q;
  assign speed_out     = speed_q;

endmodule

// File: rtl/motor_control.sv
// Two-channel DC motor command decoder: detects byte changes on a level-held
// input, parses SYNC/command frames and drives two slew-limited motor stages.
module motor_control
  import motor_control_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter logic [7:0]  CRUISE_SPEED = 8'd200,
  parameter logic [15:0] RAMP_DIV     = 16'd256
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] data_in,
  output logic       m1_direction_out,
  output logic       m2_direction_out,
  output logic [7:0] m1_speed_out,
  output logic [7:0] m2_speed_out
);

  state_e      state_q, state_d;
  logic [7:0]  last_byte_q;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  target_q, target_d;
  logic        pend1_q, pend1_d;
  logic        pend2_q, pend2_d;
  logic        byte_event;
  logic        tick;

  // A byte is new only when it differs from the value seen last clock.
  assign byte_event = (data_in != last_byte_q);

  // Free-running ramp prescaler; tick on the terminal count.
  assign tick = (cnt_q == (RAMP_DIV - 16'd1));

  // Prescaler next value: wrap after the terminal count.
  always_comb begin
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  // Frame parser and command decoder; both motors share one target.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    if (byte_event) begin
      if (data_in == SYNC_BYTE) begin
        state_d = WAIT_CMD;
      end else if (state_q == WAIT_CMD) begin
        state_d = WAIT_SYNC;
        case (data_in)
          CMD_STOP:  target_d = 8'd0;
          CMD_FWD:   begin pend1_d = DIR_FWD; pend2_d = DIR_FWD; target_d = CRUISE_SPEED; end
          CMD_REV:   begin pend1_d = DIR_REV; pend2_d = DIR_REV; target_d = CRUISE_SPEED; end
          CMD_LEFT:  begin pend1_d = DIR_REV; pend2_d = DIR_FWD; target_d = CRUISE_SPEED; end
          CMD_RIGHT: begin pend1_d = DIR_FWD; pend2_d = DIR_REV; target_d = CRUISE_SPEED; end
          default:   ;
        endcase
      end
    end
  end

  // Parser, prescaler and command registers; reset wins over a same-edge byte.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= WAIT_SYNC;
      last_byte_q <= 8'h00;
      cnt_q       <= 16'd0;
      target_q    <= 8'd0;
      pend1_q     <= DIR_FWD;
      pend2_q     <= DIR_FWD;
    end else begin
      state_q     <= state_d;
      last_byte_q <= data_in;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
    end
  end

  motor_ramp u_m1 (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .tick          (tick),
    .target        (target_q),
    .pending_dir   (pend1_q),
    .direction_out (m1_direction_out),
    .speed_out     (m1_speed_out)
  );

  motor_ramp u_m2 (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .tick          (tick),
    .target        (target_q),
    .pending_dir   (pend2_q),
    .direction_out (m2_direction_out),
    .speed_out     (m2_speed_out)
  );

endmodule

// File: tb/tb_motor_control.sv
// Directed bench for motor_control with CRUISE_SPEED=8 and RAMP_DIV=1.
// Each step drives inputs mid-cycle, queues the expected outputs for the
// following rising edge, then pops and compares just after that edge.
module tb_motor_control;

  typedef struct packed {
    logic       m1d;
    logic [7:0] m1s;
    logic       m2d;
    logic [7:0] m2s;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       m1_direction_out, m2_direction_out;
  logic [7:0] m1_speed_out, m2_speed_out;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  motor_control #(
    .SYNC_BYTE    (8'h80),
    .CRUISE_SPEED (8'd8),
    .RAMP_DIV     (16'd1)
  ) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .data_in          (data_in),
    .m1_direction_out (m1_direction_out),
    .m2_direction_out (m2_direction_out),
    .m1_speed_out     (m1_speed_out),
    .m2_speed_out     (m2_speed_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t mk(input logic d1, input int s1, input logic d2, input int s2);
    exp_t e;
    e.m1d = d1;
    e.m1s = 8'(s1);
    e.m2d = d2;
    e.m2s = 8'(s2);
    return e;
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 8) return 8;
    return v;
  endfunction

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic r, input logic [7:0] b, input exp_t e);
    exp_t got, want;
    @(negedge clk_in);
    reset_in = r;
    data_in  = b;
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    want = sb_q.pop_front();
    got  = {m1_direction_out, m1_speed_out, m2_direction_out, m2_speed_out};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s t=%0t got m1=%0d/%0d m2=%0d/%0d want m1=%0d/%0d m2=%0d/%0d",
             tag, $time, got.m1d, got.m1s, got.m2d, got.m2s,
             want.m1d, want.m1s, want.m2d, want.m2s);
    end
  endtask

  // Hold one byte for n clocks while outputs are expected to stay constant.
  task automatic hold(input string tag, input logic [7:0] b, input int n, input exp_t e);
    for (int i = 0; i < n; i++) step(tag, 1'b0, b, e);
  endtask

  initial begin
    // 1: reset values, then idle on data_in=0
    for (int i = 0; i < 2; i++) step("reset", 1'b1, 8'h00, mk(1, 0, 1, 0));
    hold("idle", 8'h00, 20, mk(1, 0, 1, 0));

    // 2: forward ramp 0..8, first step one edge after the command edge
    hold("fwd_sync", 8'h80, 10, mk(1, 0, 1, 0));
    for (int k = 0; k < 10; k++)
      step("fwd_ramp", 1'b0, 8'h01, mk(1, clamp(k), 1, clamp(k)));

    // 3: reversal brakes to zero, flips direction at zero, then ramps back up
    hold("rev_sync", 8'h80, 10, mk(1, 8, 1, 8));
    for (int k = 0; k < 20; k++) begin
      if (k == 0)      step("rev", 1'b0, 8'h02, mk(1, 8, 1, 8));
      else if (k <= 8) step("rev_brake", 1'b0, 8'h02, mk(1, 8 - k, 1, 8 - k));
      else if (k == 9) step("rev_flip", 1'b0, 8'h02, mk(0, 0, 0, 0));
      else             step("rev_rise", 1'b0, 8'h02, mk(0, clamp(k - 9), 0, clamp(k - 9)));
    end

    // Stop with directions held at reverse
    hold("stop_sync", 8'h80, 10, mk(0, 8, 0, 8));
    for (int k = 0; k < 10; k++)
      step("stop_ramp", 1'b0, 8'h00, mk(0, clamp(8 - k), 0, clamp(8 - k)));

    // 4: spin left from stop: m1 stays reverse, m2 flips forward at zero first
    hold("left_sync", 8'h80, 10, mk(0, 0, 0, 0));
    for (int k = 0; k < 12; k++) begin
      if (k == 0) step("left", 1'b0, 8'h03, mk(0, 0, 0, 0));
      else        step("left", 1'b0, 8'h03, mk(0, clamp(k), 1, clamp(k - 1)));
    end
    // Repeated sync bytes form a single event; stop then keeps directions
    hold("sync_rep", 8'h80, 3, mk(0, 8, 1, 8));
    hold("sync_rep", 8'h80, 3, mk(0, 8, 1, 8));
    for (int k = 0; k < 12; k++)
      step("left_stop", 1'b0, 8'h00, mk(0, clamp(8 - k), 1, clamp(8 - k)));

    // 5: framing - command without sync is ignored
    hold("nosync", 8'h01, 10, mk(0, 0, 1, 0));
    // Invalid command returns to WAIT_SYNC, so the following command is ignored
    hold("inv_sync", 8'h80, 5, mk(0, 0, 1, 0));
    hold("inv_cmd", 8'h77, 5, mk(0, 0, 1, 0));
    hold("inv_after", 8'h01, 5, mk(0, 0, 1, 0));
    // Get moving forward, then 128,0,1: only the stop takes effect
    hold("gap_sync", 8'h80, 5, mk(0, 0, 1, 0));
    for (int k = 0; k < 12; k++) begin
      if (k == 0) step("gap_fwd", 1'b0, 8'h01, mk(0, 0, 1, 0));
      else        step("gap_fwd", 1'b0, 8'h01, mk(1, clamp(k - 1), 1, clamp(k)));
    end
    hold("gap_sync2", 8'h80, 5, mk(1, 8, 1, 8));
    for (int k = 0; k < 12; k++) begin
      if (k < 4) step("gap_stop", 1'b0, 8'h00, mk(1, clamp(8 - k), 1, clamp(8 - k)));
      else       step("gap_ign", 1'b0, 8'h01, mk(1, clamp(8 - k), 1, clamp(8 - k)));
    end

    // 6: reset mid-ramp at speed 5
    hold("rst_sync", 8'h80, 5, mk(1, 0, 1, 0));
    for (int k = 0; k < 6; k++)
      step("rst_ramp", 1'b0, 8'h01, mk(1, k, 1, k));
    step("rst_mid", 1'b1, 8'h01, mk(1, 0, 1, 0));
    // Command alone after reset is ignored (parser back in WAIT_SYNC)
    hold("rst_after", 8'h01, 10, mk(1, 0, 1, 0));
    // Parser still works after reset
    hold("rst_sync2", 8'h80, 5, mk(1, 0, 1, 0));
    for (int k = 0; k < 10; k++)
      step("rst_fwd", 1'b0, 8'h01, mk(1, clamp(k), 1, clamp(k)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
